// File: rtl/seg_scan_if.sv
// Pin bundle between the application value registers and the 7-segment scan driver.
// The master side owns the display values; the slave side drives the board pins.
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   disp_data;
    logic [DIGITS-1:0]     dot_en;
    logic [DIGITS-1:0]     blink_en;
    logic                  lz_en;
    logic [3:0]            bright;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     sel;
    logic                  frame_done;

    modport master (
        output load, disp_data, dot_en, blink_en, lz_en, bright,
        input  seg, sel, frame_done
    );

    modport slave (
        input  load, disp_data, dot_en, blink_en, lz_en, bright,
        output seg, sel, frame_done
    );
endinterface

// File: rtl/seg_scan_drv.sv
// Multi-digit 7-segment scan driver: double-buffered values, frame-synchronous swap,
// inter-digit blanking, leading-zero suppression, per-digit blink and 16-level PWM.
module seg_scan_drv #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int DIGITS         = 8,
    parameter int DIGIT_TIME_US  = 1000,
    parameter int BLANK_US       = 20,
    parameter int BLINK_HZ       = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int SLOT   = CLK_FREQ / 1_000_000 * DIGIT_TIME_US;
    localparam int BLANK  = CLK_FREQ / 1_000_000 * BLANK_US;
    localparam int HB     = CLK_FREQ / (2 * BLINK_HZ);
    localparam int SLOT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int HB_W   = (HB > 1) ? $clog2(HB) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    logic [0:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [3:0]          pwm_cnt;
    logic [HB_W-1:0]     blink_cnt;
    logic                blink_phase;

    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   act_dot;
    logic [DIGITS-1:0]   act_blink;
    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dot;
    logic [DIGITS-1:0]   sh_blink;
    logic                pending;

    logic [7:0]          seg_p1;
    logic [DIGITS-1:0]   sel_p1;
    logic                frame_done_p1;

    logic                slot_end;
    logic                frame_end;
    logic [DIGITS-1:0]   lz_blank;
    logic                lz_run;
    logic [3:0]          cur_nib;
    logic [7:0]          seg_on;
    logic [DIGITS-1:0]   sel_on;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    function automatic logic [7:0] seg_pol(input logic [7:0] s);
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic [DIGITS-1:0] sel_pol(input logic [DIGITS-1:0] s);
        return SEL_ACTIVE_LOW ? ~s : s;
    endfunction

    assign slot_end  = (slot_cnt == SLOT_W'(SLOT - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
    assign cur_nib   = act_data[idx*4 +: 4];

    // Suppression runs from the top digit down and stops at the first visible content.
    always_comb begin
        lz_blank = '0;
        lz_run   = bus.lz_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run      = lz_run && (act_data[4*i +: 4] == 4'h0) && !act_dot[i];
            lz_blank[i] = lz_run;
        end
    end

    always_comb begin
        seg_on = '0;
        sel_on = '0;
        if (state == ST_SHOW) begin
            if (!lz_blank[idx] && !(blink_phase && act_blink[idx]))
                seg_on = {act_dot[idx], seg7(cur_nib)};
            if (pwm_cnt <= bus.bright)
                sel_on[idx] = 1'b1;
        end
    end

    // Stage p0: scan sequencing, blink timebase and display buffers
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            idx         <= '0;
            slot_cnt    <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            act_data    <= '0;
            act_dot     <= '0;
            act_blink   <= '0;
            sh_data     <= '0;
            sh_dot      <= '0;
            sh_blink    <= '0;
            pending     <= 1'b0;
        end else begin
            if (slot_end) begin
                slot_cnt <= '0;
                state    <= ST_BLANK;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                slot_cnt <= slot_cnt + SLOT_W'(1);
                if (state == ST_BLANK && slot_cnt == SLOT_W'(BLANK - 1)) begin
                    state   <= ST_SHOW;
                    pwm_cnt <= '0;
                end else if (state == ST_SHOW) begin
                    pwm_cnt <= pwm_cnt + 4'd1;
                end
            end

            if (blink_cnt == HB_W'(HB - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + HB_W'(1);
            end

            if (frame_end && pending) begin
                act_data  <= sh_data;
                act_dot   <= sh_dot;
                act_blink <= sh_blink;
                pending   <= 1'b0;
            end
            // A load in the swap cycle lands in the shadow and waits for the next frame.
            if (bus.load) begin
                sh_data  <= bus.disp_data;
                sh_dot   <= bus.dot_en;
                sh_blink <= bus.blink_en;
                pending  <= 1'b1;
            end
        end
    end

    // Stage p1: registered pins
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            seg_p1        <= seg_pol(8'h00);
            sel_p1        <= sel_pol('0);
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= seg_pol(seg_on);
            sel_p1        <= sel_pol(sel_on);
            frame_done_p1 <= frame_end;
        end
    end

    assign bus.seg        = seg_p1;
    assign bus.sel        = sel_p1;
    assign bus.frame_done = frame_done_p1;
endmodule

// File: tb/tb_seg_scan_drv.sv
// Bench for seg_scan_drv: per-cycle comparison against a frame-arithmetic model
// plus literal glyph/timing expectations at known slot positions.
module tb_seg_scan_drv;
    localparam int DIG   = 4;
    localparam int SLOT  = 10;
    localparam int BLANK = 2;
    localparam int FRAME = DIG * SLOT;
    localparam int HB    = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_if #(.DIGITS(DIG)) bus();

    seg_scan_drv #(
        .CLK_FREQ(1_000_000),
        .DIGITS(DIG),
        .DIGIT_TIME_US(10),
        .BLANK_US(2),
        .BLINK_HZ(2500),
        .SEG_ACTIVE_LOW(1'b1),
        .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: elapsed cycles since reset, displayed and pending values
    int          t;
    logic [15:0] m_data, s_data;
    logic [3:0]  m_dot, s_dot, m_blink, s_blink;
    bit          pend;

    logic [7:0]  e_seg;
    logic [3:0]  e_sel;
    logic        e_fd;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        int p, d, w;
        logic [7:0] seg_hi;
        logic [3:0] sel_hi;
        bit sup, bl;
        @(posedge clk);
        if (!rst_n) begin
            e_seg = 8'hFF; e_sel = 4'hF; e_fd = 1'b0;
            t = 0; pend = 0;
            m_data = '0; m_dot = '0; m_blink = '0;
            s_data = '0; s_dot = '0; s_blink = '0;
        end else begin
            p = t % FRAME;
            d = p / SLOT;
            w = p % SLOT;
            seg_hi = '0;
            sel_hi = '0;
            if (w >= BLANK) begin
                if (((w - BLANK) % 16) <= int'(bus.bright)) sel_hi[d] = 1'b1;
                sup = bus.lz_en && (d > 0) && ((m_data >> (4 * d)) == 0) && ((m_dot >> d) == 0);
                bl  = (((t / HB) % 2) == 1) && m_blink[d];
                if (!sup && !bl) seg_hi = {m_dot[d], glyph[m_data[4*d +: 4]]};
            end
            e_seg = ~seg_hi;
            e_sel = ~sel_hi;
            e_fd  = (p == FRAME - 1);
            if (p == FRAME - 1 && pend) begin
                m_data = s_data; m_dot = s_dot; m_blink = s_blink; pend = 0;
            end
            if (bus.load) begin
                s_data = bus.disp_data; s_dot = bus.dot_en; s_blink = bus.blink_en; pend = 1;
            end
            t++;
        end
        #1;
        check("model_seg", {8'h00, bus.seg}, {8'h00, e_seg});
        check("model_sel", {12'h000, bus.sel}, {12'h000, e_sel});
        check("model_frame_done", {15'h0, bus.frame_done}, {15'h0, e_fd});
    end

    task automatic do_load(input logic [15:0] data, input logic [3:0] dot, input logic [3:0] blink);
        bus.disp_data = data;
        bus.dot_en    = dot;
        bus.blink_en  = blink;
        bus.load      = 1'b1;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_done_timeout got none expected pulse within 100 cycles");
        end
    endtask

    initial begin
        bus.load = 0; bus.disp_data = '0; bus.dot_en = '0; bus.blink_en = '0;
        bus.lz_en = 0; bus.bright = 4'd15;
        repeat (2) @(negedge clk);
        check("reset_seg", {8'h00, bus.seg}, 16'h00FF);
        check("reset_sel", {12'h000, bus.sel}, 16'h000F);
        check("reset_fd", {15'h0, bus.frame_done}, 16'h0000);
        rst_n = 1'b1;

        // Basic scan of 0x12AF
        do_load(16'h12AF, 4'b0000, 4'b0000);
        wait_fd();
        @(negedge clk);
        check("t1_blank_sel", {12'h000, bus.sel}, 16'h000F);
        check("t1_blank_seg", {8'h00, bus.seg}, 16'h00FF);
        repeat (2) @(negedge clk);
        check("t1_d0_seg", {8'h00, bus.seg}, 16'h008E);
        check("t1_d0_sel", {12'h000, bus.sel}, 16'h000E);
        repeat (10) @(negedge clk);
        check("t1_d1_seg", {8'h00, bus.seg}, 16'h0088);
        check("t1_d1_sel", {12'h000, bus.sel}, 16'h000D);
        repeat (10) @(negedge clk);
        check("t1_d2_seg", {8'h00, bus.seg}, 16'h00A4);
        check("t1_d2_sel", {12'h000, bus.sel}, 16'h000B);
        repeat (10) @(negedge clk);
        check("t1_d3_seg", {8'h00, bus.seg}, 16'h00F9);
        check("t1_d3_sel", {12'h000, bus.sel}, 16'h0007);

        // Mid-frame load, then two loads in one frame
        wait_fd();
        repeat (15) @(negedge clk);
        do_load(16'h0000, 4'b0000, 4'b0000);
        wait_fd();
        do_load(16'h3333, 4'b0000, 4'b0000);
        do_load(16'h4567, 4'b0000, 4'b0000);
        wait_fd();
        repeat (3) @(negedge clk);
        check("t2_last_load_wins", {8'h00, bus.seg}, 16'h00F8);

        // Brightness 3: selected for pwm 0..3 only
        bus.bright = 4'd3;
        wait_fd();
        repeat (6) @(negedge clk);
        check("t4_pwm3_sel", {12'h000, bus.sel}, 16'h000E);
        @(negedge clk);
        check("t4_pwm4_sel", {12'h000, bus.sel}, 16'h000F);
        check("t4_pwm4_seg", {8'h00, bus.seg}, 16'h00F8);
        bus.bright = 4'd15;

        // Leading-zero suppression
        bus.lz_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        wait_fd();
        repeat (3) @(negedge clk);
        check("t3_d0_seg", {8'h00, bus.seg}, 16'h00C0);
        repeat (10) @(negedge clk);
        check("t3_d1_seg", {8'h00, bus.seg}, 16'h0092);
        repeat (20) @(negedge clk);
        check("t3_d3_suppressed", {8'h00, bus.seg}, 16'h00FF);
        do_load(16'h0050, 4'b0100, 4'b0000);
        wait_fd();
        repeat (23) @(negedge clk);
        check("t3_d2_dot", {8'h00, bus.seg}, 16'h0040);
        repeat (10) @(negedge clk);
        check("t3_d3_dot_suppressed", {8'h00, bus.seg}, 16'h00FF);
        bus.lz_en = 1'b0;

        // Blink on digit2 across several half periods
        do_load(16'h12AF, 4'b0000, 4'b0100);
        repeat (900) @(negedge clk);

        // Reset during digit2 SHOW with a pending load
        wait_fd();
        repeat (24) @(negedge clk);
        do_load(16'h9999, 4'b0000, 4'b0000);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_seg", {8'h00, bus.seg}, 16'h00FF);
        check("t6_rst_sel", {12'h000, bus.sel}, 16'h000F);
        check("t6_rst_fd", {15'h0, bus.frame_done}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_blank_sel", {12'h000, bus.sel}, 16'h000F);
        repeat (2) @(negedge clk);
        check("t6_d0_seg", {8'h00, bus.seg}, 16'h00C0);
        check("t6_d0_sel", {12'h000, bus.sel}, 16'h000E);
        wait_fd();
        repeat (3) @(negedge clk);
        check("t6_pending_dropped", {8'h00, bus.seg}, 16'h00C0);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            bus.disp_data = 16'($urandom);
            bus.dot_en    = 4'($urandom);
            bus.blink_en  = 4'($urandom);
            bus.load      = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) bus.lz_en = ~bus.lz_en;
            if ($urandom_range(0, 49) == 0) bus.bright = 4'($urandom);
            rst_n = ($urandom_range(0, 699) != 0);
            @(negedge clk);
        end
        bus.load = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
